// File: rtl/seq_divider_7_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the stage-7 signed divider.
package div_pkg_7;

  localparam int DIVIDEND_W = 24;
  localparam int DIVISOR_W  = 12;

  localparam int QMAX = 2047;
  localparam int QMIN = -2048;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider_7_if.sv
// Start/done handshake plus operand and result bus of the stage-7 divider.
interface seq_divider_7_if #(
  parameter int DIVIDEND_W = div_pkg_7::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg_7::DIVISOR_W
);

  logic                         en;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic signed [DIVISOR_W-1:0]  quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         result_rdy;
  logic                         busy;
  logic                         ovf;
  logic                         div_by_zero;

  modport master (
    output en, dividend, divisor,
    input  quotient, remainder, result_rdy, busy, ovf, div_by_zero
  );

  modport slave (
    input  en, dividend, divisor,
    output quotient, remainder, result_rdy, busy, ovf, div_by_zero
  );

endinterface

// File: rtl/seq_divider_7.sv
// Sequential signed restoring divider, one quotient bit per cycle, saturating 12-bit quotient.
// Optional build macro DIV_ROUND_EN: round the quotient half away from zero.
module seq_divider_7
  import div_pkg_7::*;
#(
  parameter int DIVIDEND_W = div_pkg_7::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg_7::DIVISOR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_7_if.slave  bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W:0] POS_LIM   = (DIVIDEND_W+1)'(QMAX);
  localparam logic [DIVIDEND_W:0] NEG_LIM   = (DIVIDEND_W+1)'(-QMIN);
  localparam logic [DIVISOR_W-1:0] Q_MAX    = DIVISOR_W'(QMAX);
  localparam logic [DIVISOR_W-1:0] Q_MIN    = DIVISOR_W'(QMIN);

  state_t state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DIVIDEND_W-1:0] quo, quo_nx;
  logic [DIVISOR_W:0]    rem, rem_nx;
  logic [DIVISOR_W-1:0]  dvs, dvs_nx;
  logic                  sd, sd_nx, sv, sv_nx;

  logic [DIVISOR_W-1:0]  q_r, q_nx, r_r, r_nx;
  logic                  rdy_r, rdy_nx, busy_r, busy_nx, ovf_r, ovf_nx, dz_r, dz_nx;

  // Magnitudes are formed one bit wider so -2^23 and -2048 negate without wrapping.
  logic [DIVIDEND_W:0]   dvd_ext, dvd_abs;
  logic [DIVISOR_W:0]    dvs_ext, dvs_abs;
  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W+1:0]  trial;
  logic                  round_up;
  logic [DIVIDEND_W:0]   mag;
  logic                  neg;

  always_comb begin
    dvd_ext = {bus.dividend[DIVIDEND_W-1], bus.dividend};
    dvd_abs = bus.dividend[DIVIDEND_W-1] ? -dvd_ext : dvd_ext;
    dvs_ext = {bus.divisor[DIVISOR_W-1], bus.divisor};
    dvs_abs = bus.divisor[DIVISOR_W-1] ? -dvs_ext : dvs_ext;
    rem_sh  = {rem[DIVISOR_W-1:0], quo[DIVIDEND_W-1]};
    trial   = {1'b0, rem_sh} - {2'b00, dvs};
`ifdef DIV_ROUND_EN
    round_up = (dvs != '0) && ({rem, 1'b0} >= {2'b00, dvs});
`else
    round_up = 1'b0;
`endif
    mag = {1'b0, quo} + {{DIVIDEND_W{1'b0}}, round_up};
    neg = sd ^ sv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      sd     <= 1'b0;
      sv     <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      rdy_r  <= 1'b0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      quo    <= quo_nx;
      rem    <= rem_nx;
      dvs    <= dvs_nx;
      sd     <= sd_nx;
      sv     <= sv_nx;
      q_r    <= q_nx;
      r_r    <= r_nx;
      rdy_r  <= rdy_nx;
      busy_r <= busy_nx;
      ovf_r  <= ovf_nx;
      dz_r   <= dz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    quo_nx   = quo;
    rem_nx   = rem;
    dvs_nx   = dvs;
    sd_nx    = sd;
    sv_nx    = sv;
    q_nx     = q_r;
    r_nx     = r_r;
    rdy_nx   = 1'b0;
    busy_nx  = busy_r;
    ovf_nx   = ovf_r;
    dz_nx    = dz_r;
    unique case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (bus.en) begin
          quo_nx   = dvd_abs[DIVIDEND_W-1:0];
          dvs_nx   = dvs_abs[DIVISOR_W-1:0];
          sd_nx    = bus.dividend[DIVIDEND_W-1];
          sv_nx    = bus.divisor[DIVISOR_W-1];
          rem_nx   = '0;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy_nx = 1'b1;
        if (!trial[DIVISOR_W+1]) begin
          rem_nx = trial[DIVISOR_W:0];
          quo_nx = {quo[DIVIDEND_W-2:0], 1'b1};
        end else begin
          rem_nx = rem_sh;
          quo_nx = {quo[DIVIDEND_W-2:0], 1'b0};
        end
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST_STEP) state_nx = DONE;
      end
      DONE: begin
        // Busy stays up through the result_rdy cycle and drops on the following edge.
        busy_nx  = 1'b1;
        rdy_nx   = 1'b1;
        state_nx = IDLE;
        if (dvs == '0) begin
          q_nx   = sd ? Q_MIN : Q_MAX;
          r_nx   = '0;
          ovf_nx = 1'b1;
          dz_nx  = 1'b1;
        end else begin
          dz_nx = 1'b0;
          r_nx  = sd ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
          if (neg) begin
            ovf_nx = (mag > NEG_LIM);
            q_nx   = ovf_nx ? Q_MIN : -mag[DIVISOR_W-1:0];
          end else begin
            ovf_nx = (mag > POS_LIM);
            q_nx   = ovf_nx ? Q_MAX : mag[DIVISOR_W-1:0];
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.result_rdy  = rdy_r;
  assign bus.busy        = busy_r;
  assign bus.ovf         = ovf_r;
  assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider_7.sv
// Directed bench for seq_divider_7: vector table for arithmetic, hand sequences for control corners.
module tb_seq_divider_7;

`ifdef DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  seq_divider_7_if #(.DIVIDEND_W(24), .DIVISOR_W(12)) bus ();

  seq_divider_7 #(.DIVIDEND_W(24), .DIVISOR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int ovf;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Pulse en for one cycle; lat is the number of edges after capture until result_rdy is seen.
  task automatic applyStimulus(input int a, input int b, output int lat);
    @(negedge clk);
    bus.en       = 1'b1;
    bus.dividend = 24'(a);
    bus.divisor  = 12'(b);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    checkOutput("busy_after_capture", int'(bus.busy), 1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.result_rdy) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int rdy_seen;
    tests_run    = 0;
    tests_failed = 0;
    bus.en       = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;

    vecs[0]  = '{1000, 7, ROUND ? 143 : 142, 6, 0, 0, 25};
    vecs[1]  = '{-1000, 7, ROUND ? -143 : -142, -6, 0, 0, 25};
    vecs[2]  = '{1000, -7, ROUND ? -143 : -142, 6, 0, 0, 25};
    vecs[3]  = '{-1000, -7, ROUND ? 143 : 142, -6, 0, 0, 25};
    vecs[4]  = '{100000, 3, 2047, 1, 1, 0, 25};
    vecs[5]  = '{-100000, 3, -2048, -1, 1, 0, 25};
    vecs[6]  = '{-6144, 3, -2048, 0, 0, 0, 25};
    vecs[7]  = '{5, 0, 2047, 0, 1, 1, 1};
    vecs[8]  = '{-5, 0, -2048, 0, 1, 1, 1};
    vecs[9]  = '{999, 2, ROUND ? 500 : 499, 1, 0, 0, 25};
    vecs[10] = '{-999, 2, ROUND ? -500 : -499, -1, 0, 0, 25};
    vecs[11] = '{14, 7, 2, 0, 0, 0, 25};
    vecs[12] = '{-8388608, 1, -2048, 0, 1, 0, 25};
    vecs[13] = '{2047, 1, 2047, 0, 0, 0, 25};
    vecs[14] = '{2048, 1, 2047, 0, 1, 0, 25};
    vecs[15] = '{-2048, 1, -2048, 0, 0, 0, 25};

    #12;
    checkOutput("rst_quotient", int'(bus.quotient), 0);
    checkOutput("rst_remainder", int'(bus.remainder), 0);
    checkOutput("rst_rdy", int'(bus.result_rdy), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_ovf", int'(bus.ovf), 0);
    checkOutput("rst_dz", int'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d_quotient", i), int'(bus.quotient), vecs[i].q);
      checkOutput($sformatf("v%0d_remainder", i), int'(bus.remainder), vecs[i].r);
      checkOutput($sformatf("v%0d_ovf", i), int'(bus.ovf), vecs[i].ovf);
      checkOutput($sformatf("v%0d_dz", i), int'(bus.div_by_zero), vecs[i].dz);
      checkOutput($sformatf("v%0d_busy_on_rdy", i), int'(bus.busy), 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_rdy_pulse", i), int'(bus.result_rdy), 0);
      checkOutput($sformatf("v%0d_busy_low", i), int'(bus.busy), 0);
      checkOutput($sformatf("v%0d_q_held", i), int'(bus.quotient), vecs[i].q);
    end

    // en pulsed mid-CALC with other operands must not disturb the running division.
    @(negedge clk);
    bus.en       = 1'b1;
    bus.dividend = 24'(1000);
    bus.divisor  = 12'(7);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.en       = 1'b1;
    bus.dividend = 24'(50);
    bus.divisor  = 12'(5);
    @(negedge clk);
    bus.en = 1'b0;
    lat = -1;
    for (int k = 7; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.result_rdy) begin
        lat = k;
        break;
      end
    end
    checkOutput("busy_en_latency", lat, 25);
    checkOutput("busy_en_quotient", int'(bus.quotient), ROUND ? 143 : 142);
    checkOutput("busy_en_remainder", int'(bus.remainder), 6);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_en_not_queued", int'(bus.busy), 0);

    // Asynchronous reset at CALC cycle 10 abandons the division and clears held outputs.
    @(negedge clk);
    bus.en       = 1'b1;
    bus.dividend = 24'(-1000);
    bus.divisor  = 12'(7);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_quotient", int'(bus.quotient), 0);
    checkOutput("midrst_remainder", int'(bus.remainder), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_ovf", int'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.result_rdy || bus.busy) rdy_seen++;
    end
    checkOutput("midrst_no_result", rdy_seen, 0);

    // Fresh start after reset completes normally.
    applyStimulus(14, 7, lat);
    checkOutput("post_rst_latency", lat, 25);
    checkOutput("post_rst_quotient", int'(bus.quotient), 2);
    checkOutput("post_rst_remainder", int'(bus.remainder), 0);
    checkOutput("post_rst_ovf", int'(bus.ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
